// File: rtl/btn_debounce_if.sv
// Pin-side bundle for btn_debounce: raw pin level in, clean level and strobes out.
// dbg_state mirrors the filter FSM (0=STABLE_LOW 1=WAIT_HIGH 2=STABLE_HIGH 3=WAIT_LOW).
interface btn_debounce_if;
   logic       raw;
   logic       q;
   logic       rise;
   logic       fall;
   logic       long_press;
   logic [1:0] dbg_state;

   // Handshake: none. raw is a free-running asynchronous level; q/rise/fall/long_press
   // are registered in the clk domain and rise/fall/long_press are valid for exactly one cycle.
   modport master (
      output raw,
      input  q,
      input  rise,
      input  fall,
      input  long_press,
      input  dbg_state
   );

   modport slave (
      input  raw,
      output q,
      output rise,
      output fall,
      output long_press,
      output dbg_state
   );
endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: multi-flop synchronizer followed by a per-edge stability filter.
// Optional long-hold strobe is built only when BTN_DEBOUNCE_LONG_PRESS_EN is defined.
module btn_debounce #(
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = 12000,
   parameter bit INIT_LEVEL        = 1'b0,
   parameter int LONG_PRESS_CYCLES = 24000000
) (
   input logic           clk,
   input logic           rst,
   btn_debounce_if.slave bus
);

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      WAIT_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      WAIT_LOW    = 2'd3
   } state_t;

   localparam int          CW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW:0] DEB_LIM   = (CW+1)'(DEBOUNCE_CYCLES);
   localparam bit          DIRECT    = (DEBOUNCE_CYCLES == 1);
   localparam state_t      RST_STATE = INIT_LEVEL ? STABLE_HIGH : STABLE_LOW;

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   s;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [CW:0]   cnt_inc;
   logic          qualified;
   logic          q_r;
   logic          q_nxt;
   logic          rise_r;
   logic          rise_nxt;
   logic          fall_r;
   logic          fall_nxt;

   // Plain flop chain; nothing may sit between stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_ff <= {SYNC_STAGES{INIT_LEVEL}};
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.raw};
      end
   end

   assign s         = sync_ff[SYNC_STAGES-1];
   assign cnt_inc   = {1'b0, cnt} + (CW+1)'(1);
   assign qualified = (cnt_inc == DEB_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RST_STATE;
         cnt    <= '0;
         q_r    <= INIT_LEVEL;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         q_r    <= q_nxt;
         rise_r <= rise_nxt;
         fall_r <= fall_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         STABLE_LOW: begin
            if (s) state_nxt = DIRECT ? STABLE_HIGH : WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (!s)            state_nxt = STABLE_LOW;
            else if (qualified) state_nxt = STABLE_HIGH;
         end
         STABLE_HIGH: begin
            if (!s) state_nxt = DIRECT ? STABLE_LOW : WAIT_LOW;
         end
         WAIT_LOW: begin
            if (s)              state_nxt = STABLE_HIGH;
            else if (qualified) state_nxt = STABLE_LOW;
         end
         default: state_nxt = RST_STATE;
      endcase
   end

   // cnt defaults to zero: every path that leaves or stays out of a WAIT state clears it.
   always_comb begin
      cnt_nxt  = '0;
      q_nxt    = q_r;
      rise_nxt = 1'b0;
      fall_nxt = 1'b0;
      case (state)
         STABLE_LOW: begin
            if (s) begin
               if (DIRECT) begin
                  q_nxt    = 1'b1;
                  rise_nxt = 1'b1;
               end else begin
                  cnt_nxt = CW'(1);
               end
            end
         end
         WAIT_HIGH: begin
            if (s) begin
               if (qualified) begin
                  q_nxt    = 1'b1;
                  rise_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt_inc[CW-1:0];
               end
            end
         end
         STABLE_HIGH: begin
            if (!s) begin
               if (DIRECT) begin
                  q_nxt    = 1'b0;
                  fall_nxt = 1'b1;
               end else begin
                  cnt_nxt = CW'(1);
               end
            end
         end
         WAIT_LOW: begin
            if (!s) begin
               if (qualified) begin
                  q_nxt    = 1'b0;
                  fall_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt_inc[CW-1:0];
               end
            end
         end
         default: begin
            q_nxt = INIT_LEVEL;
         end
      endcase
   end

   assign bus.q         = q_r;
   assign bus.rise      = rise_r;
   assign bus.fall      = fall_r;
   assign bus.dbg_state = state;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
   localparam int          HW     = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HW:0] LP_LIM = (HW+1)'(LONG_PRESS_CYCLES);

   logic [HW-1:0] hcnt;
   logic [HW-1:0] hcnt_nxt;
   logic [HW:0]   hcnt_inc;
   logic          lp_r;
   logic          lp_nxt;

   assign hcnt_inc = {1'b0, hcnt} + (HW+1)'(1);

   // The rise cycle is hold cycle 1; saturation at the limit keeps it to one pulse per press.
   always_comb begin
      hcnt_nxt = hcnt;
      lp_nxt   = 1'b0;
      if (rise_nxt) begin
         hcnt_nxt = HW'(1);
         lp_nxt   = (LP_LIM == (HW+1)'(1));
      end else if (!q_nxt) begin
         hcnt_nxt = '0;
      end else if (hcnt_inc <= LP_LIM) begin
         hcnt_nxt = hcnt_inc[HW-1:0];
         lp_nxt   = (hcnt_inc == LP_LIM);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         lp_r <= 1'b0;
      end else begin
         hcnt <= hcnt_nxt;
         lp_r <= lp_nxt;
      end
   end

   assign bus.long_press = lp_r;
`else
   assign bus.long_press = 1'b0;
`endif

endmodule
